// File: rtl/uart_rx.sv
// Purpose: 8N1 UART receiver with 16x oversampling and a single-entry valid/ready holding register.
// Latency: 2 clk input sync + 1 clk edge detect, then 152*DIV clk from start detection to rxValid/flags.
// Backpressure: a frame completing while rxValid is held without rxReady is dropped and raises sticky overrun.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        asynchronous active-high reset; aborts any frame in flight with no flags
//   rx         serial line, idle high, asynchronous to clk
//   rxReady    consumer accepts the held byte when high together with rxValid
//   rxData     received byte, stable while rxValid is high
//   rxValid    holding register full
//   overrun    sticky; a good frame was dropped because the holding register was full
//   frameError one-clk pulse; stop bit sampled low, byte discarded
module uart_rx #(
    parameter int CLOCK_RATE = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rxReady,
    output logic [7:0] rxData,
    output logic       rxValid,
    output logic       overrun,
    output logic       frameError
);

    // Clocks per oversample tick; integer truncation is intentional. Must be >= 2.
    localparam int DIV = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);

    // Tick positions within a bit period (16 ticks per bit).
    localparam logic [3:0] MID_BIT  = 4'd7;   // 8th tick after the start edge
    localparam logic [3:0] LAST_BIT = 4'd15;  // 16th tick after the previous sample

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rxState_t;

    rxState_t        state;
    logic            rxMeta;
    logic            rxSync;
    logic            rxPrev;
    logic            startEdge;
    logic            startDet;
    logic [CW-1:0]   tickCnt;
    logic            tick;
    logic [3:0]      sampleCnt;
    logic [2:0]      bitCnt;
    logic [7:0]      shiftReg;
    logic            consume;

    // ------------------------------------------------------------------
    // Input synchronizer and falling-edge detector. All three flops reset
    // high so an idle line produces no edge; a line held low through reset
    // release does produce one, and is then treated as a real start.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
            rxPrev <= 1'b1;
        end else begin
            rxMeta <= rx;
            rxSync <= rxMeta;
            rxPrev <= rxSync;
        end
    end

    assign startEdge = rxPrev & ~rxSync;
    assign startDet  = (state == IDLE) && startEdge;

    // ------------------------------------------------------------------
    // Oversample tick. Free-running, but re-phased to the start edge so the
    // mid-bit sample points are measured from the detected edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tickCnt <= '0;
        end else if (startDet || tick) begin
            tickCnt <= '0;
        end else begin
            tickCnt <= tickCnt + CW'(1);
        end
    end

    assign tick = (tickCnt == TICK_LAST);

    // A held byte leaves the holding register on any edge where both are high.
    assign consume = rxValid & rxReady;

    // ------------------------------------------------------------------
    // Frame FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sampleCnt  <= '0;
            bitCnt     <= '0;
            shiftReg   <= '0;
            rxData     <= '0;
            rxValid    <= 1'b0;
            overrun    <= 1'b0;
            frameError <= 1'b0;
        end else begin
            frameError <= 1'b0;

            // Consumption; a frame completing in this same cycle overrides
            // rxValid below, so the new byte is kept and no overrun occurs.
            if (consume) begin
                rxValid <= 1'b0;
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (startEdge) begin
                        state     <= START;
                        sampleCnt <= '0;
                    end
                end

                START: begin
                    if (tick) begin
                        if (sampleCnt == MID_BIT) begin
                            sampleCnt <= '0;
                            if (!rxSync) begin
                                state  <= DATA;
                                bitCnt <= '0;
                            end else begin
                                // Line went back high before mid-bit: a glitch.
                                state <= IDLE;
                            end
                        end else begin
                            sampleCnt <= sampleCnt + 4'd1;
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        // The 4-bit counter wraps 15 -> 0 on each sample, which
                        // is also the clear required on the DATA -> STOP move.
                        sampleCnt <= sampleCnt + 4'd1;
                        if (sampleCnt == LAST_BIT) begin
                            // Right shift: first bit on the line ends up in bit 0.
                            shiftReg <= {rxSync, shiftReg[7:1]};
                            bitCnt   <= bitCnt + 3'd1;
                            if (bitCnt == 3'd7) begin
                                state <= STOP;
                            end
                        end
                    end
                end

                STOP: begin
                    if (tick) begin
                        if (sampleCnt == LAST_BIT) begin
                            state     <= IDLE;
                            sampleCnt <= '0;
                            if (rxSync) begin
                                if (!rxValid || rxReady) begin
                                    rxData  <= shiftReg;
                                    rxValid <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end else begin
                                frameError <= 1'b1;
                            end
                        end else begin
                            sampleCnt <= sampleCnt + 4'd1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios followed by randomized frames, all
// checked against a transaction-level model of the holding register
// (byte queue, valid/overrun flags, frame-error count).
module tb_uart_rx;

    // Small divider keeps frames short: DIV = 1e6 / (15625*16) = 4.
    localparam int CLK_HZ  = 1000000;
    localparam int BAUD    = 15625;
    localparam int DIV     = CLK_HZ / (BAUD * 16);
    localparam int BIT_CLK = 16 * DIV;
    localparam int FULL    = 10 * BIT_CLK;
    // Line edge -> outputs: 2 sync flops + 1 edge-detect flop + 152 ticks.
    localparam int LAT     = 3 + 152 * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rxReady;
    logic [7:0] rxData;
    logic       rxValid;
    logic       overrun;
    logic       frameError;

    uart_rx #(
        .CLOCK_RATE(CLK_HZ),
        .BAUD_RATE (BAUD),
        .OVERSAMPLE(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rxReady   (rxReady),
        .rxData    (rxData),
        .rxValid   (rxValid),
        .overrun   (overrun),
        .frameError(frameError)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- monitor (sampled 1 time unit after negedge) ----------------
    int         cyc = 0;
    logic [7:0] gotArr [0:255];
    int         gotN = 0;
    int         feCnt = 0;
    int         feRun = 0;
    int         feMaxRun = 0;
    int         validRise = -1;
    int         validHigh = 0;
    logic       prevValid = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        #1;
        if (rxValid && rxReady && gotN < 256) begin
            gotArr[gotN] = rxData;
            gotN++;
        end
        if (frameError) begin
            feCnt++;
            feRun++;
            if (feRun > feMaxRun) feMaxRun = feRun;
        end else begin
            feRun = 0;
        end
        if (rxValid) validHigh++;
        if (rxValid && !prevValid) validRise = cyc;
        prevValid = rxValid;
    end

    // ---------------- reference model ----------------
    logic       mValid = 1'b0;
    logic [7:0] mData = 8'h00;
    logic       mOvr = 1'b0;
    int         expFe = 0;
    logic [7:0] expArr [0:255];
    int         expN = 0;
    int         rdIdx = 0;

    task automatic modelConsume();
        if (mValid) begin
            expArr[expN] = mData;
            expN++;
            mValid = 1'b0;
            mOvr   = 1'b0;
        end
    endtask

    task automatic modelReset();
        mValid = 1'b0;
        mData  = 8'h00;
        mOvr   = 1'b0;
    endtask

    // Outcome of one complete frame with rxReady held at readyHeld throughout.
    task automatic modelFrame(input logic [7:0] d, input logic stopOk, input logic readyHeld);
        if (!stopOk) begin
            expFe++;
        end else if (readyHeld) begin
            mData = d;
            expArr[expN] = d;
            expN++;
        end else if (mValid) begin
            mOvr = 1'b1;
        end else begin
            mValid = 1'b1;
            mData  = d;
        end
    endtask

    task automatic checkState(input string tag);
        check({tag, ".valid"}, 32'(rxValid), 32'(mValid));
        check({tag, ".data"}, 32'(rxData), 32'(mData));
        check({tag, ".overrun"}, 32'(overrun), 32'(mOvr));
        check({tag, ".feCount"}, feCnt, expFe);
        check({tag, ".rxCount"}, gotN, expN);
        while (rdIdx < gotN && rdIdx < expN) begin
            check({tag, ".byte"}, 32'(gotArr[rdIdx]), 32'(expArr[rdIdx]));
            rdIdx++;
        end
    endtask

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic sendFrame(input logic [7:0] d, input logic stopBit, input int limit);
        logic [9:0] f;
        f = {stopBit, d, 1'b0};
        for (int c = 0; c < limit; c++) begin
            rx = f[c / BIT_CLK];
            @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic setReady(input logic v);
        @(negedge clk);
        rxReady = v;
        if (v) modelConsume();
    endtask

    task automatic pulseReady();
        @(negedge clk);
        rxReady = 1'b1;
        modelConsume();
        @(negedge clk);
        rxReady = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int startCyc;
        int vh;
        int fe0;
        int lat;
        logic [7:0] d;
        logic ok;
        logic r;

        rst = 1'b1;
        rx = 1'b1;
        rxReady = 1'b0;
        idle(4);
        check("reset.valid", 32'(rxValid), 0);
        check("reset.data", 32'(rxData), 0);
        check("reset.overrun", 32'(overrun), 0);
        check("reset.frameError", 32'(frameError), 0);
        rst = 1'b0;
        idle(8);

        // 0xA5 with rxReady high: one-cycle valid, latency from the start edge.
        setReady(1'b1);
        startCyc = cyc;
        vh = validHigh;
        sendFrame(8'hA5, 1'b1, FULL);
        modelFrame(8'hA5, 1'b1, 1'b1);
        idle(8);
        lat = validRise - startCyc;
        check("a5.latency", (lat >= LAT - 3 && lat <= LAT + 3) ? LAT : lat, LAT);
        check("a5.validCycles", validHigh - vh, 1);
        setReady(1'b0);
        checkState("a5");

        // 0x3C then 0xC3 with rxReady low: overrun, first byte kept.
        sendFrame(8'h3C, 1'b1, FULL);
        modelFrame(8'h3C, 1'b1, 1'b0);
        idle(8);
        sendFrame(8'hC3, 1'b1, FULL);
        modelFrame(8'hC3, 1'b1, 1'b0);
        idle(8);
        checkState("overrun");
        pulseReady();
        #1;
        checkState("overrunClear");

        // 0x81 with stop bit low, then 0x55.
        fe0 = feCnt;
        sendFrame(8'h81, 1'b0, FULL);
        modelFrame(8'h81, 1'b0, 1'b0);
        idle(BIT_CLK);
        check("ferr.pulses", feCnt - fe0, 1);
        checkState("ferr");
        setReady(1'b1);
        sendFrame(8'h55, 1'b1, FULL);
        modelFrame(8'h55, 1'b1, 1'b1);
        idle(8);
        setReady(1'b0);
        checkState("after55");

        // 4-tick glitch on an idle line.
        rx = 1'b0;
        idle(4 * DIV);
        rx = 1'b1;
        idle(12 * BIT_CLK);
        checkState("glitch");

        // 0xF0 held, then 0x0F completes exactly as rxReady consumes 0xF0.
        sendFrame(8'hF0, 1'b1, FULL);
        modelFrame(8'hF0, 1'b1, 1'b0);
        idle(8);
        fork
            sendFrame(8'h0F, 1'b1, FULL);
            begin
                repeat (LAT - 1) @(negedge clk);
                rxReady = 1'b1;
                @(negedge clk);
                rxReady = 1'b0;
                #1;
                check("simul.valid", 32'(rxValid), 1);
                check("simul.data", 32'(rxData), 32'h0F);
                check("simul.overrun", 32'(overrun), 0);
            end
        join
        modelConsume();
        modelFrame(8'h0F, 1'b1, 1'b0);
        idle(8);
        checkState("simul");

        // Make state non-trivial (overrun), then reset in the middle of bit 3.
        sendFrame(8'h12, 1'b1, FULL);
        modelFrame(8'h12, 1'b1, 1'b0);
        idle(8);
        checkState("preReset");
        sendFrame(8'hB7, 1'b1, 4 * BIT_CLK + BIT_CLK / 2);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        check("midRst.valid", 32'(rxValid), 0);
        check("midRst.data", 32'(rxData), 0);
        check("midRst.overrun", 32'(overrun), 0);
        check("midRst.frameError", 32'(frameError), 0);
        rx = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2 * BIT_CLK);
        setReady(1'b1);
        sendFrame(8'h99, 1'b1, FULL);
        modelFrame(8'h99, 1'b1, 1'b1);
        idle(8);
        setReady(1'b0);
        checkState("after99");

        // Line held low through reset release: start seen, ends in frame error.
        rx = 1'b0;
        rst = 1'b1;
        modelReset();
        idle(3);
        rst = 1'b0;
        idle(FULL);
        rx = 1'b1;
        expFe++;
        idle(2 * BIT_CLK);
        checkState("lowThroughReset");

        // Randomized frames.
        for (int i = 0; i < 12; i++) begin
            d  = 8'($urandom);
            ok = ($urandom % 5) != 0;
            r  = 1'($urandom % 2);
            setReady(r);
            sendFrame(d, ok, FULL);
            modelFrame(d, ok, r);
            idle(BIT_CLK / 2 + int'($urandom % BIT_CLK));
            setReady(1'b0);
            if ($urandom % 3 == 0) pulseReady();
            idle(2);
            checkState("rnd");
        end

        check("ferr.maxWidth", feMaxRun, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver with 16x oversampling that recovers 8N1 frames from the asynchronous serial line and presents each byte through a single-entry valid/ready holding register. It is the receive-side consumer of the baud timing used across the UART blocks. It derives its own oversample tick from the system clock, so the whole block runs in one clock domain. Overrun and framing errors are reported to the consuming logic.

## Interface
- CLOCK_RATE, 50000000, system clock frequency in Hz
- BAUD_RATE, 9600, line rate in bit/s
- OVERSAMPLE, 16, ticks per bit period; fixed at 16
- DIV (localparam), CLOCK_RATE/(BAUD_RATE*OVERSAMPLE) with integer truncation (325 at defaults); must be ≥2; tick counter width is $clog2(DIV)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- rx  in  1  serial line; idle high; asynchronous to clk
- rxReady  in  1  consumer accepts the held byte when high together with rxValid
- rxData  out  8  received byte; stable while rxValid is high
- rxValid  out  1  holding register full
- overrun  out  1  sticky; a completed frame was dropped because the holding register was full
- frameError  out  1  one-cycle pulse; stop bit sampled low

## Operation
- Input sync: two flops on rx, both reset to 1. An edge detector compares against a previous-value flop, which also resets to 1.
- Tick: counter runs 0..DIV-1 and pulses tick for one clk when it reaches DIV-1, then wraps to 0. The counter is cleared to 0 on start detection.
- sampleCnt is 4 bits and increments on each tick. It is cleared on start detection and on each state transition.
- FSM states:
  - IDLE: on a falling edge of synced rx, go to START and clear the counters.
  - START: on the 8th tick (mid-bit), if synced rx = 0, go to DATA with bitCnt = 0. Otherwise treat it as a glitch and return to IDLE with no flags.
  - DATA: on every 16th tick, shift synced rx into the shift register MSB-first-in-right-shift, so the first bit received is the LSB. After bit index 7 is captured, go to STOP.
  - STOP: on the 16th tick, sample synced rx and return to IDLE.
    - Sample = 1 and holding register empty (or being emptied this cycle): load rxData and set rxValid.
    - Sample = 1 and holding register full: set overrun; keep the old rxData.
    - Sample = 0: pulse frameError and discard the byte.
- Handshake: when rxValid and rxReady are both high on a clk edge, the byte is consumed. rxValid drops the next cycle unless a new byte loads in the same cycle. Consumption also clears overrun.
- Simultaneous consume and frame completion: the new byte loads, rxValid stays 1, and overrun is not set.
- A line held low after a frame error produces no new start until it has been seen high, because start detection is edge-based.

## Timing
- Reset values: rxData = 0x00, rxValid = 0, overrun = 0, frameError = 0, FSM = IDLE, all counters 0.
- Asynchronous rst mid-frame aborts the frame immediately with no flags raised.
- If rx is held low through reset release, it is seen as a start edge. The resulting frame ends with frameError if the line stays low.
- Input latency: 2 clk from rx to synced rx, plus 1 clk for edge detection.
- Frame latency: stop sample occurs 8 + 16*9 = 152 ticks = 152*DIV clk after start detection (49400 clk at defaults).
- rxValid, overrun and frameError all rise on the clk edge immediately following the stop-sample tick.
- frameError is high for exactly 1 clk.
- Output registers only change on stop completion, consumption, or rst.

## Test plan
- Send 0xA5 at 9600 baud with rxReady = 1 -> rxData = 0xA5, rxValid high for 1 clk, no flags; latency 152*325 clk ±3 from the start edge.
- Send 0x3C then 0xC3 with rxReady = 0 -> rxData stays 0x3C, overrun = 1 after the second stop bit. Pulse rxReady -> rxValid = 0 and overrun = 0 next cycle.
- Send 0x81 with the stop bit forced low -> frameError 1-clk pulse, rxValid stays 0. Then send 0x55 -> received correctly.
- Drive a 4-tick low glitch on idle rx -> returns to IDLE, no rxValid, no frameError.
- Complete a frame (0x0F) in the same cycle rxReady consumes the previous byte 0xF0 -> rxData = 0x0F, rxValid stays 1, overrun stays 0.
- Assert rst in the middle of bit 3 of a frame -> all outputs reset immediately. The next clean frame 0x99 is received correctly.
